// File: rtl/mem_readout_merge.sv
// mem_readout_merge: drains NCH per-event memories into one header-led valid/ready stream
module mem_readout_merge #(
    parameter int NCH = 12,
    parameter int DW = 54,
    parameter int AW = 6,
    parameter int BXW = 3,
    parameter int RR = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BXW-1:0]    BX,
    input  logic [NCH*AW-1:0] number_in,
    output logic [NCH*AW-1:0] read_add,
    input  logic [NCH*DW-1:0] mem_dat,
    output logic [DW-1:0]     out_dat,
    output logic [3:0]        out_chan,
    output logic              out_header,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = DW + 5;
    typedef enum logic [1:0] {IDLE, HEADER, READ} state_t;
    state_t state;
    logic [AW-1:0] cnt [NCH];
    logic [AW-1:0] addr [NCH];
    logic [DW-1:0] md [NCH];
    logic [EW-1:0] fifo [FIFO_DEPTH];
    logic [BXW-1:0] bx_r;
    logic [3:0] ich, rr_ptr, gch, base;
    logic [PW-1:0] rd, wr;
    logic [OW-1:0] occ;
    logic [15:0] nz;
    logic [DW-1:0] hdr_word;
    logic [EW-1:0] push_word, head;
    logic inflight, room, any, gnt, push, pop, fin;

    function automatic logic [3:0] wrap(input logic [4:0] v);
        return v >= 5'(NCH) ? 4'(v - 5'(NCH)) : v[3:0];
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        assign read_add[g*AW +: AW] = addr[g];
        assign md[g] = mem_dat[g*DW +: DW];
        assign nz[g] = cnt[g] != '0;
    end
    if (NCH < 16) begin : g_pad
        assign nz[15:NCH] = '0;
    end

    assign base = RR != 0 ? wrap(5'(rr_ptr) + 5'd1) : 4'd0;
    // occupancy plus the read in flight must leave a free slot for it to land
    assign room = 32'(occ) + 32'(inflight) < 32'(FIFO_DEPTH - 1);

    always_comb begin
        gch = '0;
        any = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (nz[wrap(5'(base) + 5'(k))]) begin
                gch = wrap(5'(base) + 5'(k));
                any = 1'b1;
            end
        end
    end

    always_comb begin
        hdr_word = '0;
        hdr_word[DW-1] = 1'b1;
        hdr_word[BXW +: NCH] = nz[NCH-1:0];
        hdr_word[BXW-1:0] = bx_r;
    end

    assign gnt = any && room && state == READ && !start;
    assign push = !start && (state == HEADER || inflight);
    assign push_word = state == HEADER ? {1'b1, 4'd0, hdr_word} : {1'b0, ich, md[ich]};
    assign head = fifo[rd];
    assign out_valid = occ != '0;
    assign pop = out_valid && out_ready;
    assign out_dat = out_valid ? head[DW-1:0] : '0;
    assign out_chan = out_valid ? head[DW +: 4] : 4'd0;
    assign out_header = out_valid && head[EW-1];
    assign busy = state != IDLE;
    assign fin = state == READ && nz == '0 && !inflight && occ == '0;
    assign done = fin && !start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            bx_r <= '0;
            inflight <= 1'b0;
            ich <= '0;
            rr_ptr <= '0;
            rd <= '0;
            wr <= '0;
            occ <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
                addr[i] <= '0;
            end
        end else if (start) begin
            state <= HEADER;
            bx_r <= BX;
            inflight <= 1'b0;
            rr_ptr <= 4'(NCH - 1);
            rd <= '0;
            wr <= '0;
            occ <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= number_in[i*AW +: AW];
                addr[i] <= '0;
            end
        end else begin
            state <= state == HEADER ? READ : fin ? IDLE : state;
            inflight <= gnt;
            ich <= gch;
            if (gnt) begin
                cnt[gch] <= cnt[gch] - 1'b1;
                addr[gch] <= addr[gch] + 1'b1;
                rr_ptr <= gch;
            end
            if (push)
                wr <= nxt(wr);
            if (pop)
                rd <= nxt(rd);
            occ <= occ + OW'(push) - OW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr] <= push_word;
    end

    assert property (@(posedge clk) disable iff (reset) !(push && !pop && occ == OW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_mem_readout_merge.sv
// tb_mem_readout_merge: fixed-priority and round-robin instances against an ordering model of the merged stream
module tb_mem_readout_merge;
    localparam int NCH = 12, DW = 54, AW = 6, BXW = 3, FD = 4, WW = DW + 5;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, out_ready = 1'b0, st_q = 1'b0;
    logic [BXW-1:0] bx = '0;
    logic [NCH*AW-1:0] number_in = '0;
    logic [NCH*AW-1:0] ra [2];
    logic [NCH*DW-1:0] md [2];
    logic [DW-1:0] dat [2];
    logic [3:0] chn [2];
    logic hd [2], v [2], bsy [2], dn [2], hold_v [2];
    logic [DW-1:0] mem [NCH][64];
    logic [WW-1:0] rxw [2][1024];
    logic [WW-1:0] expw [2][1024];
    logic [WW-1:0] held [2];
    int rxt [2][1024];
    int rxn [2], expn [2], dn_cnt [2], dn_t [2];
    int cnts [NCH];
    int cyc = 0, s_cyc = 0, n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    mem_readout_merge #(.NCH(NCH), .DW(DW), .AW(AW), .BXW(BXW), .RR(0), .FIFO_DEPTH(FD)) u0 (
        .clk(clk), .reset(reset), .start(start), .BX(bx), .number_in(number_in),
        .read_add(ra[0]), .mem_dat(md[0]), .out_dat(dat[0]), .out_chan(chn[0]),
        .out_header(hd[0]), .out_valid(v[0]), .out_ready(out_ready), .busy(bsy[0]), .done(dn[0]));

    mem_readout_merge #(.NCH(NCH), .DW(DW), .AW(AW), .BXW(BXW), .RR(1), .FIFO_DEPTH(FD)) u1 (
        .clk(clk), .reset(reset), .start(start), .BX(bx), .number_in(number_in),
        .read_add(ra[1]), .mem_dat(md[1]), .out_dat(dat[1]), .out_chan(chn[1]),
        .out_header(hd[1]), .out_valid(v[1]), .out_ready(out_ready), .busy(bsy[1]), .done(dn[1]));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        st_q <= start | reset;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < NCH; c++)
                md[k][c*DW +: DW] <= mem[c][ra[k][c*AW +: AW]];
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (hold_v[k] && !st_q && !reset)
                check("hold", 64'({v[k], hd[k], chn[k], dat[k]}), 64'({1'b1, held[k]}));
            if (v[k] && out_ready && rxn[k] < 1024) begin
                rxw[k][rxn[k]] = {hd[k], chn[k], dat[k]};
                rxt[k][rxn[k]] = cyc;
                rxn[k]++;
            end
            if (dn[k]) begin
                if (dn_cnt[k] == 0) dn_t[k] = cyc;
                dn_cnt[k]++;
            end
            hold_v[k] = v[k] && !out_ready;
            held[k] = {hd[k], chn[k], dat[k]};
        end
    end

    task automatic push_exp(input int k, input logic [WW-1:0] w);
        expw[k][expn[k]] = w;
        expn[k]++;
    endtask

    // Fixed priority drains channels in index order; round-robin emits one item per
    // non-empty channel per round, rounds taken in index order.
    task automatic begin_event();
        logic [DW-1:0] hdr;
        hdr = '0;
        hdr[DW-1] = 1'b1;
        hdr[BXW-1:0] = bx;
        for (int c = 0; c < NCH; c++) begin
            hdr[BXW + c] = cnts[c] != 0;
            number_in[c*AW +: AW] = AW'(cnts[c]);
            for (int a = 0; a < 64; a++) mem[c][a] = DW'({$urandom, $urandom});
        end
        for (int k = 0; k < 2; k++) begin
            expn[k] = 0;
            push_exp(k, {1'b1, 4'd0, hdr});
        end
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < cnts[c]; a++) push_exp(0, {1'b0, 4'(c), mem[c][a]});
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < NCH; c++)
                if (cnts[c] > r) push_exp(1, {1'b0, 4'(c), mem[c][r]});
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s_cyc = cyc;
        for (int k = 0; k < 2; k++) begin
            rxn[k] = 0;
            dn_cnt[k] = 0;
            dn_t[k] = -1;
            hold_v[k] = 1'b0;
        end
    endtask

    task automatic run_to_done(input int mode);
        int t = 0;
        while (!(dn_cnt[0] > 0 && dn_cnt[1] > 0) && t < 3000) begin
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (t % 3 == 0) : ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            t++;
        end
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("done_count", 64'(dn_cnt[k]), 1);
            check("busy_after", 64'(bsy[k]), 0);
            check("length", 64'(rxn[k]), 64'(expn[k]));
            for (int i = 0; i < expn[k] && i < rxn[k]; i++)
                check("word", 64'(rxw[k][i]), 64'(expw[k][i]));
            for (int c = 0; c < NCH; c++)
                check("final_addr", 64'(ra[k][c*AW +: AW]), 64'(cnts[c]));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            hold_v[k] = 1'b0;
            rxn[k] = 0;
            dn_cnt[k] = 0;
            dn_t[k] = -1;
        end
        cnts = '{default: 0};
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_valid", 64'(v[k]), 0);
            check("rst_busy", 64'(bsy[k]), 0);
            check("rst_done", 64'(dn[k]), 0);
            check("rst_dat", 64'(dat[k]), 0);
            check("rst_chan", 64'(chn[k]), 0);
            check("rst_hdr", 64'(hd[k]), 0);
            for (int c = 0; c < NCH; c++) check("rst_addr", 64'(ra[k][c*AW +: AW]), 0);
        end

        cnts[0] = 2;
        cnts[3] = 1;
        bx = 3'd5;
        out_ready = 1'b1;
        begin_event();
        run_to_done(0);
        for (int k = 0; k < 2; k++) begin
            check("hdr_time", 64'(rxt[k][0]), 64'(s_cyc + 1));
            check("w0_time", 64'(rxt[k][1]), 64'(s_cyc + 3));
            check("w1_time", 64'(rxt[k][2]), 64'(s_cyc + 4));
            check("w2_time", 64'(rxt[k][3]), 64'(s_cyc + 5));
            check("done_time", 64'(dn_t[k]), 64'(s_cyc + 6));
        end

        cnts = '{default: 0};
        cnts[0] = 2;
        cnts[1] = 2;
        bx = 3'd1;
        begin_event();
        run_to_done(0);

        cnts = '{default: 0};
        cnts[2] = 3;
        bx = 3'd7;
        begin_event();
        run_to_done(1);

        cnts = '{default: 0};
        bx = 3'd4;
        begin_event();
        run_to_done(2);

        cnts = '{default: 0};
        cnts[5] = 10;
        bx = 3'd2;
        out_ready = 1'b1;
        begin_event();
        for (int t = 0; t < 200 && rxn[0] < 4; t++) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cnts[5] = 0;
        cnts[9] = 4;
        cnts[1] = 2;
        bx = 3'd6;
        begin_event();
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("abort_hdr_valid", 64'(v[k]), 1);
            check("abort_hdr_flag", 64'(hd[k]), 1);
            check("abort_hdr_dat", 64'(dat[k]), 64'(expw[k][0][DW-1:0]));
        end
        @(posedge clk);
        #1;
        run_to_done(2);

        cnts = '{default: 0};
        cnts[0] = 3;
        cnts[5] = 20;
        bx = 3'd1;
        out_ready = 1'b1;
        begin_event();
        repeat (6) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("areset_valid", 64'(v[k]), 0);
            check("areset_busy", 64'(bsy[k]), 0);
            check("areset_done", 64'(dn[k]), 0);
            check("areset_addr5", 64'(ra[k][5*AW +: AW]), 0);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        for (int e = 0; e < 6; e++) begin
            for (int c = 0; c < NCH; c++)
                cnts[c] = $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 4)) : 0;
            if (e == 2) cnts[7] = 63;
            bx = BXW'($urandom);
            begin_event();
            run_to_done(e % 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
